// File: rtl/sonata_pkg.sv
// Shared Sonata top-level constants: switch debounce defaults and switch bit map.
package sonata_pkg;

    localparam int unsigned SysClkFreq = 30_000_000;

    localparam int unsigned SwDebounceWidth       = 16;
    localparam int unsigned SwDebounceTickCycles  = SysClkFreq / 1000;
    localparam int unsigned SwDebounceStableTicks = 5;

    localparam int unsigned SwNavLsb  = 0;
    localparam int unsigned SwNavMsb  = 4;
    localparam int unsigned SwUserLsb = 5;
    localparam int unsigned SwUserMsb = 12;
    localparam int unsigned SwSelLsb  = 13;
    localparam int unsigned SwSelMsb  = 15;

    typedef struct packed {
        logic [2:0] sel;
        logic [7:0] user;
        logic [4:0] nav;
    } sw_pins_t;

endpackage

// File: rtl/switch_debounce_tick.sv
// Sample-tick prescaler shared by every debounced switch bit.
module debounce_tick
    import sonata_pkg::*;
#(
    parameter int unsigned TickCycles = SwDebounceTickCycles
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int unsigned PrescW = $clog2(TickCycles);

    logic [PrescW-1:0] presc;

    assign tick_o = (presc == PrescW'(TickCycles - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            presc <= '0;
        end else if (tick_o) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

endmodule

// File: rtl/switch_debounce.sv
// Two-flop synchroniser plus per-bit tick-qualified debounce for board switches.
// Edge pulse outputs are only built when SWITCH_DEBOUNCE_EDGE_EN is defined.
module switch_debounce
    import sonata_pkg::*;
#(
    parameter int unsigned      Width       = SwDebounceWidth,
    parameter int unsigned      TickCycles  = SwDebounceTickCycles,
    parameter int unsigned      StableTicks = SwDebounceStableTicks,
    parameter logic [Width-1:0] RstVal      = {Width{1'b1}}
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] sw_i,
    output logic [Width-1:0] sw_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o,
    output logic             tick_o
);

    localparam int unsigned     CntW    = $clog2(StableTicks + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(StableTicks - 1);

    logic                        tick;
    logic                        tick_q;
    logic [Width-1:0]            sync_q1, sync_q2;
    logic [Width-1:0]            sw_q, sw_d;
    logic [Width-1:0][CntW-1:0]  cnt_q, cnt_d;

    debounce_tick #(
        .TickCycles(TickCycles)
    ) u_tick (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .tick_o(tick)
    );

    // Any cycle where the synchronised pin agrees with the output restarts qualification.
    for (genvar i = 0; i < Width; i++) begin : g_bit
        logic diff, accept;
        assign diff     = sync_q2[i] ^ sw_q[i];
        assign accept   = diff && tick && (cnt_q[i] == CntLast);
        assign sw_d[i]  = accept ? sync_q2[i] : sw_q[i];
        assign cnt_d[i] = (!diff || accept) ? '0 :
                          tick              ? cnt_q[i] + 1'b1 :
                                              cnt_q[i];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q1 <= RstVal;
            sync_q2 <= RstVal;
            sw_q    <= RstVal;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            sync_q1 <= sw_i;
            sync_q2 <= sync_q1;
            sw_q    <= sw_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick;
        end
    end

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    logic [Width-1:0] sw_prev_q, rise_q, fall_q;

    // sw_prev_q tracks sw_q from reset, so reset itself never looks like an edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sw_prev_q <= RstVal;
            rise_q    <= '0;
            fall_q    <= '0;
        end else begin
            sw_prev_q <= sw_q;
            rise_q    <= sw_q & ~sw_prev_q;
            fall_q    <= ~sw_q & sw_prev_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    assign rise_o = '0;
    assign fall_o = '0;
`endif

    assign sw_o   = sw_q;
    assign tick_o = tick_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce: driver pushes model expectations, monitor pops and compares.
module tb_switch_debounce;

    localparam int          W  = 4;
    localparam int          TC = 4;
    localparam int          ST = 3;
    localparam logic [3:0]  RV = 4'hF;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    localparam bit EdgeEn = 1'b1;
`else
    localparam bit EdgeEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw_i = 4'h0;
    logic [3:0] sw_o, rise_o, fall_o;
    logic       tick_o;

    always #5 clk = ~clk;

    switch_debounce #(
        .Width(W), .TickCycles(TC), .StableTicks(ST), .RstVal(RV)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .sw_i(sw_i),
        .sw_o(sw_o), .rise_o(rise_o), .fall_o(fall_o), .tick_o(tick_o)
    );

    typedef struct packed {
        logic [3:0] sw;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: pin history delayed two clocks, ticks every TC cycles after
    // release, and a count of consecutive ticks on which the pin disagreed with the output.
    logic [3:0] pin_d1, pin_d2;
    logic [3:0] m_sw, m_sw_prev;
    int         m_cyc;
    int         m_run[4];

    function automatic void model_step(input logic r, input logic [3:0] p);
        exp_t e;
        logic t;
        if (!r) begin
            pin_d1 = RV; pin_d2 = RV; m_sw = RV; m_sw_prev = RV; m_cyc = 0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            e = '{sw: RV, rise: 4'h0, fall: 4'h0, tick: 1'b0};
        end else begin
            t = ((m_cyc % TC) == TC - 1);
            e.rise = EdgeEn ? (m_sw & ~m_sw_prev) : 4'h0;
            e.fall = EdgeEn ? (~m_sw & m_sw_prev) : 4'h0;
            m_sw_prev = m_sw;
            for (int i = 0; i < 4; i++) begin
                if (pin_d2[i] == m_sw[i]) begin
                    m_run[i] = 0;
                end else if (t) begin
                    m_run[i]++;
                    if (m_run[i] == ST) begin
                        m_sw[i] = pin_d2[i];
                        m_run[i] = 0;
                    end
                end
            end
            pin_d2 = pin_d1;
            pin_d1 = p;
            m_cyc++;
            e.sw   = m_sw;
            e.tick = t;
        end
        exp_q.push_back(e);
    endfunction

    task automatic step(input logic r, input logic [3:0] p);
        @(negedge clk);
        rst_n = r;
        sw_i  = p;
        model_step(r, p);
    endtask

    task automatic hold(input int n, input logic [3:0] p);
        repeat (n) step(1'b1, p);
    endtask

    // Monitor
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{sw: sw_o, rise: rise_o, fall: fall_o, tick: tick_o};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs @%0t: got sw=%h rise=%h fall=%h tick=%b, want sw=%h rise=%h fall=%h tick=%b",
                             $time, a.sw, a.rise, a.fall, a.tick, e.sw, e.rise, e.fall, e.tick);
                end
            end
        end
    end

    initial begin
        int n;
        bit seen;
        logic [3:0] p;

        // Reset with pins low, release with pins high; first tick_o is 4 edges after release
        repeat (5) step(1'b0, 4'h0);
        seen = 0;
        for (n = 1; n <= 8; n++) begin
            step(1'b1, 4'hF);
            @(posedge clk); #2;
            if (tick_o === 1'b1) begin seen = 1; break; end
        end
        checks++;
        if (!seen || n != 4) begin
            errors++;
            $display("FAIL first_tick: got edge %0d (seen=%0d), want 4", n, seen);
        end
        hold(20, 4'hF);

        // Clean step on bit 0
        seen = 0;
        for (n = 1; n <= 20; n++) begin
            step(1'b1, 4'hE);
            @(posedge clk); #2;
            if (sw_o[0] === 1'b0) begin seen = 1; break; end
        end
        checks++;
        if (!seen || n < 9 || n > 14) begin
            errors++;
            $display("FAIL step_latency: got %0d cycles (seen=%0d), want 9..14", n, seen);
        end
        hold(20, 4'hE);

        // Bounce on bit 1, then a real change
        hold(6, 4'hC);
        hold(6, 4'hE);
        hold(20, 4'hC);

        // Simultaneous changes on all bits
        hold(20, 4'hF);
        seen = 0;
        for (n = 1; n <= 20; n++) begin
            step(1'b1, 4'h0);
            @(posedge clk); #2;
            if (sw_o !== 4'hF) begin seen = 1; break; end
        end
        checks++;
        if (!seen || sw_o !== 4'h0) begin
            errors++;
            $display("FAIL simultaneous: got sw_o=%h (seen=%0d), want 0", sw_o, seen);
        end
        hold(20, 4'h0);
        hold(20, 4'hF);

        // Reset in the middle of qualification on bit 2
        hold(8, 4'hB);
        step(1'b0, 4'hB);
        hold(20, 4'hB);
        hold(20, 4'hF);

        // Random pins, hold lengths and occasional reset
        p = 4'hF;
        repeat (60) begin
            if ($urandom_range(0, 29) == 0) step(1'b0, p);
            p = 4'($urandom);
            hold($urandom_range(1, 16), p);
        end
        hold(20, 4'hF);

        @(posedge clk); #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
